uart_receiver: RTL and testbench

- Serial UART receiver, fixed 8N1 format: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Converts an asynchronous rx line into parallel bytes, with a one-cycle valid strobe per byte.
- Used on the SoC's UART TX line in the simulation top-level to capture console output.
- Bit period is set at run time by a clock-divider input.

---
 rtl/uart_receiver.sv | 134 +++++++++++++
 tb/tb_uart_receiver.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, run-time bit period of bc+1 clocks.
// Emits a one-cycle ch_vld strobe with the received byte on ch; framing errors are dropped.
module uart_receiver (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bc,
    output logic        ch_vld,
    output logic [7:0]  ch,
    input  logic        rx
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        rx_m;
    logic        rx_s;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic [15:0] bc_lat;
    logic [15:0] bc_lat_nxt;
    logic [15:0] half;
    logic [2:0]  idx;
    logic [2:0]  idx_nxt;
    logic [7:0]  shift;
    logic [7:0]  shift_nxt;
    logic [7:0]  ch_nxt;
    logic        ch_vld_nxt;

    // Both flops reset to 1 so a reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    assign half = {1'b0, bc_lat[15:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            bc_lat <= '0;
            idx    <= '0;
            shift  <= '0;
            ch     <= '0;
            ch_vld <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            bc_lat <= bc_lat_nxt;
            idx    <= idx_nxt;
            shift  <= shift_nxt;
            ch     <= ch_nxt;
            ch_vld <= ch_vld_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt + 16'd1;
        bc_lat_nxt = bc_lat;
        idx_nxt    = idx;
        shift_nxt  = shift;
        ch_nxt     = ch;
        ch_vld_nxt = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!rx_s) begin
                    state_nxt  = START;
                    bc_lat_nxt = bc;
                end
            end
            // Validating the start bit at its centre aligns all later samples to bit centres.
            START: begin
                if (cnt == half) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DATA;
                        idx_nxt   = '0;
                    end
                end
            end
            DATA: begin
                if (cnt == bc_lat) begin
                    cnt_nxt        = '0;
                    shift_nxt[idx] = rx_s;
                    if (idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt == bc_lat) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        ch_nxt     = shift;
                        ch_vld_nxt = 1'b1;
                        state_nxt  = IDLE;
                    end else begin
                        state_nxt = WAIT_IDLE;
                    end
                end
            end
            // A held-low line after a framing error must not be taken as a new start bit.
            WAIT_IDLE: begin
                cnt_nxt = '0;
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: vector table, hand-written corner sequences and a randomized
// phase checked against a line-waveform model derived from the sample-instant rules.
module tb_uart_receiver;

    localparam int LOG_N = 32768;

    logic        clk;
    logic        rst_n;
    logic [15:0] bc;
    logic        ch_vld;
    logic [7:0]  ch;
    logic        rx;

    uart_receiver dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bc     (bc),
        .ch_vld (ch_vld),
        .ch     (ch),
        .rx     (rx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         e;
        logic [7:0] d;
    } strobe_t;

    typedef struct {
        int         bcv;
        int         start_len;
        logic [7:0] data;
        int         exp_lat;
    } vec_t;

    int        errors = 0;
    int        checks = 0;
    int        edge_n = 0;
    int        viol   = 0;
    bit        rx_log [LOG_N];
    int        bc_log [LOG_N];
    strobe_t   strobes[$];
    strobe_t   exp_q  [$];
    logic       prev_vld = 1'b0;
    logic       prev_rst = 1'b0;
    logic [7:0] prev_ch  = 8'h00;

    // Edge k is the k-th rising edge; rx_log[k] and bc_log[k] are what the DUT sampled there.
    always @(posedge clk) begin
        if (edge_n + 1 < LOG_N) begin
            rx_log[edge_n + 1] <= rx;
            bc_log[edge_n + 1] <= int'(bc);
        end
        edge_n <= edge_n + 1;
    end

    always @(posedge clk) begin
        #1;
        if (ch_vld) strobes.push_back('{e: edge_n, d: ch});
        if (ch_vld && prev_vld) viol++;
        if (rst_n && prev_rst && !ch_vld && ch != prev_ch) viol++;
        prev_vld = ch_vld;
        prev_ch  = ch;
        prev_rst = rst_n;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a falling edge; returns on a falling edge with the line back at mark.
    task automatic send_frame(input int period, input int start_len, input logic [7:0] data,
                              input logic stop, input logic scram, output int t_low);
        rx    = 1'b0;
        t_low = edge_n + 1;
        idle(start_len);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            idle(period);
            if (scram && i == 0) bc = 16'($urandom_range(0, 40));
        end
        rx = stop;
        idle(period);
        rx = 1'b1;
    endtask

    // The receiver sees rx two edges late. A start seen at edge e is checked at c = e+1+h,
    // bit k at c+(k+1)*(bc+1), the stop bit at c+9*(bc+1), using bc as sampled at edge e.
    function automatic void run_model(input int e0, input int e1);
        int e;
        int b;
        int c;
        int s;
        logic [7:0] d;
        e = e0;
        while (e <= e1) begin
            if (rx_log[e - 2]) begin
                e++;
                continue;
            end
            b = bc_log[e];
            c = e + 1 + (b / 2);
            if (rx_log[c - 2]) begin
                e = c + 1;
                continue;
            end
            s = c + 9 * (b + 1);
            if (s > e1) break;
            for (int k = 0; k < 8; k++) d[k] = rx_log[c + (k + 1) * (b + 1) - 2];
            e = s + 1;
            if (rx_log[s - 2]) begin
                exp_q.push_back('{e: s, d: d});
            end else begin
                while (e <= e1 && !rx_log[e - 2]) e++;
                e++;
            end
        end
    endfunction

    vec_t vecs[5];
    int   t;
    int   t1;
    int   e0;
    int   e1;
    int   b;
    int   kind;
    int   hl;
    logic [7:0] rd;
    logic [7:0] mid;

    initial begin
        // At bc=0 the two-edge synchronizer delay puts the start check one clock after the
        // first low sample, so that vector stretches the start bit to two clocks.
        vecs[0] = '{bcv: 9,  start_len: 10, data: 8'h41, exp_lat: 97};
        vecs[1] = '{bcv: 0,  start_len: 2,  data: 8'hFF, exp_lat: 12};
        vecs[2] = '{bcv: 3,  start_len: 4,  data: 8'h00, exp_lat: 40};
        vecs[3] = '{bcv: 15, start_len: 16, data: 8'h80, exp_lat: 154};
        vecs[4] = '{bcv: 1,  start_len: 2,  data: 8'hA7, exp_lat: 21};

        rst_n = 1'b0;
        rx    = 1'b1;
        bc    = 16'd9;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            rx = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("reset_vld", int'(ch_vld), 0);
            check("reset_ch", int'(ch), 0);
        end
        rx = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(50);
        check("post_reset_no_strobe", strobes.size(), 0);

        foreach (vecs[i]) begin
            strobes.delete();
            bc = 16'(vecs[i].bcv);
            send_frame(vecs[i].bcv + 1, vecs[i].start_len, vecs[i].data, 1'b1, 1'b0, t);
            idle(20);
            check($sformatf("vec%0d_count", i), strobes.size(), 1);
            if (strobes.size() > 0) begin
                check($sformatf("vec%0d_ch", i), int'(strobes[0].d), int'(vecs[i].data));
                check($sformatf("vec%0d_latency", i), strobes[0].e - t, vecs[i].exp_lat);
            end
        end

        strobes.delete();
        bc = 16'd9;
        send_frame(10, 10, 8'h48, 1'b1, 1'b0, t1);
        send_frame(10, 10, 8'h69, 1'b1, 1'b0, t);
        send_frame(10, 10, 8'h10, 1'b1, 1'b0, t);
        idle(20);
        check("b2b_count", strobes.size(), 3);
        if (strobes.size() == 3) begin
            check("b2b_ch0", int'(strobes[0].d), 8'h48);
            check("b2b_ch1", int'(strobes[1].d), 8'h69);
            check("b2b_ch2", int'(strobes[2].d), 8'h10);
            check("b2b_latency", strobes[0].e - t1, 97);
            check("b2b_gap01", strobes[1].e - strobes[0].e, 100);
            check("b2b_gap12", strobes[2].e - strobes[1].e, 100);
        end

        strobes.delete();
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(20);
        check("false_start_no_strobe", strobes.size(), 0);
        send_frame(10, 10, 8'h55, 1'b1, 1'b0, t);
        idle(20);
        check("after_false_count", strobes.size(), 1);
        if (strobes.size() > 0) begin
            check("after_false_ch", int'(strobes[0].d), 8'h55);
            check("after_false_latency", strobes[0].e - t, 97);
        end

        strobes.delete();
        send_frame(10, 10, 8'hA5, 1'b0, 1'b0, t);
        rx = 1'b0;
        idle(30);
        rx = 1'b1;
        idle(20);
        check("framing_no_strobe", strobes.size(), 0);
        check("framing_ch_kept", int'(ch), 8'h55);
        send_frame(10, 10, 8'h3C, 1'b1, 1'b0, t);
        idle(20);
        check("framing_next_count", strobes.size(), 1);
        if (strobes.size() > 0) begin
            check("framing_next_ch", int'(strobes[0].d), 8'h3C);
            check("framing_next_latency", strobes[0].e - t, 97);
        end

        strobes.delete();
        mid = 8'hC3;
        rx  = 1'b0;
        idle(10);
        for (int i = 0; i < 4; i++) begin
            rx = mid[i];
            idle(10);
        end
        rx = mid[4];
        idle(5);
        rst_n = 1'b0;
        #1;
        check("midreset_ch", int'(ch), 0);
        check("midreset_vld", int'(ch_vld), 0);
        @(negedge clk);
        idle(3);
        rx = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(150);
        check("midreset_no_strobe", strobes.size(), 0);
        check("midreset_ch_after", int'(ch), 0);

        strobes.delete();
        exp_q.delete();
        idle(5);
        e0 = edge_n + 1;
        for (int i = 0; i < 40; i++) begin
            b    = int'($urandom_range(1, 12));
            kind = int'($urandom_range(0, 9));
            rd   = 8'($urandom);
            bc   = 16'(b);
            if (kind == 8) begin
                hl = (b / 2 > 0) ? b / 2 : 1;
                rx = 1'b0;
                idle(int'($urandom_range(1, hl)));
                rx = 1'b1;
            end else begin
                send_frame(b + 1, b + 1, rd, kind != 9, (kind % 2) == 0, t);
                if (kind == 9) begin
                    rx = 1'b0;
                    idle(int'($urandom_range(1, 20)));
                    rx = 1'b1;
                end
            end
            idle(int'($urandom_range(0, 3)));
        end
        idle(300);
        e1 = edge_n;
        run_model(e0, e1);
        check("rand_count", strobes.size(), exp_q.size());
        for (int i = 0; i < strobes.size() && i < exp_q.size(); i++) begin
            check($sformatf("rand%0d_edge", i), strobes[i].e, exp_q[i].e);
            check($sformatf("rand%0d_ch", i), int'(strobes[i].d), int'(exp_q[i].d));
        end

        check("pulse_rules", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
